// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score-to-BCD path.
//   BIN_W   : binary score width (0..16383)
//   DIGITS  : BCD digits produced for the display
//   SAT_VAL : largest value that fits DIGITS digits; larger scores clamp to it
package score_pkg;
  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int SAT_VAL = 9999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next digit.
//   din  : nibble before correction
//   dout : corrected nibble
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_score_conv.sv
// Iterative binary-to-BCD converter for the 4-digit score display.
// One bit is consumed per clock; the result register only changes on the
// final shift, so the display never sees a partial conversion.
//   clk      : system clock
//   rst_n    : asynchronous reset, active low
//   load     : start request, honoured only while idle
//   bin_in   : binary score, captured on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd_out updated on the same edge
//   overflow : last accepted score exceeded SAT_VAL and was clamped
//   bcd_out  : packed BCD, digit 0 in [3:0]
module bcd_score_conv #(
  parameter int BIN_W   = score_pkg::BIN_W,
  parameter int DIGITS  = score_pkg::DIGITS,
  parameter int SAT_VAL = score_pkg::SAT_VAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);
  import score_pkg::*;

  localparam int               BCD_W = 4 * DIGITS;
  localparam int               CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] SAT_B = BIN_W'(SAT_VAL);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     shreg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W+BIN_W-1:0] cat_nxt;
  logic                 over_sat;

  // All digits are corrected in parallel from the pre-shift scratch value.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch[4*d +: 4]),
      .dout (scratch_adj[4*d +: 4])
    );
  end

  // Combined {scratch, shift reg} left shift; the binary MSB enters scratch
  // bit 0. The clamp guarantees the top scratch bit shifted out is always 0.
  assign cat_nxt  = {scratch_adj, shreg} << 1;
  assign over_sat = (bin_in > SAT_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also reached during the done cycle, so a held load restarts
          // on the edge after done.
          if (load) begin
            shreg    <= over_sat ? SAT_B : bin_in;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W - 1);
            overflow <= over_sat;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= cat_nxt[BCD_W+BIN_W-1:BIN_W];
          shreg   <= cat_nxt[BIN_W-1:0];
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            bcd_out <= cat_nxt[BCD_W+BIN_W-1:BIN_W];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_score_conv.sv
// Scoreboard bench for bcd_score_conv: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bcd_score_conv;
  localparam int BIN_W = 14;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, overflow;
  logic [15:0]      bcd_out;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  bcd_score_conv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bcd %0h want no result", bcd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_bcd", {16'h0, bcd_out}, {16'h0, e.bcd});
        chk("result_ovf", {31'h0, overflow}, {31'h0, e.ovf});
        chk("done_busy_low", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic wait_busy(input logic v, input string nm);
    int n = 0;
    while (busy !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got busy=%b want %b", nm, busy, v);
    end
  endtask

  // Issue one conversion from a negedge; with hold=1 load stays high so the
  // next call's bin_in is presented during the done cycle.
  task automatic run(input logic [BIN_W-1:0] v, input logic [15:0] exp_bcd,
                     input logic exp_ovf, input bit hold);
    bin_in = v;
    load   = 1'b1;
    sb.push_back('{bcd: exp_bcd, ovf: exp_ovf});
    wait_busy(1'b1, "wait_accept");
    if (!hold) load = 1'b0;
    wait_busy(1'b0, "wait_done");
  endtask

  initial begin
    int d0;
    // 1: reset, then idle with no load.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", {13'h0, busy, done, overflow, bcd_out}, 32'h0);
    end

    // 2: single conversion, exact latency and output hold.
    @(posedge clk); #1;
    load = 1'b1; bin_in = 14'd1234;
    sb.push_back('{bcd: 16'h1234, ovf: 1'b0});
    @(posedge clk); #1;
    load = 1'b0; bin_in = 14'd4321;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("t2_busy", {31'h0, busy}, 32'h1);
      chk("t2_no_done", {31'h0, done}, 32'h0);
      chk("t2_bcd_hold", {16'h0, bcd_out}, 32'h0);
    end
    @(negedge clk);
    chk("t2_done", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk("t2_done_1cyc", {31'h0, done}, 32'h0);
    chk("t2_bcd_kept", {16'h0, bcd_out}, 32'h1234);

    // 3: back-to-back with load held high.
    @(negedge clk);
    run(14'd0,    16'h0000, 1'b0, 1'b1);
    run(14'd9,    16'h0009, 1'b0, 1'b1);
    run(14'd9999, 16'h9999, 1'b0, 1'b0);
    @(negedge clk);

    // 4: clamp above SAT_VAL, then overflow clears on next accept.
    run(14'd12000, 16'h9999, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_ovf_held", {31'h0, overflow}, 32'h1);
    run(14'd42,    16'h0042, 1'b0, 1'b0);
    run(14'd16383, 16'h9999, 1'b1, 1'b0);
    run(14'd10000, 16'h9999, 1'b1, 1'b0);
    run(14'd5080,  16'h5080, 1'b0, 1'b0);
    @(negedge clk);

    // 5: load while busy is ignored.
    d0 = done_cnt;
    bin_in = 14'd500;
    load = 1'b1;
    sb.push_back('{bcd: 16'h0500, ovf: 1'b0});
    wait_busy(1'b1, "t5_accept");
    load = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = 14'd77;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_busy(1'b0, "t5_done");
    repeat (20) @(negedge clk);
    chk("t5_single_done", done_cnt - d0, 32'd1);
    chk("t5_bcd", {16'h0, bcd_out}, 32'h0500);
    chk("t5_busy_idle", {31'h0, busy}, 32'h0);

    // 6: async reset mid-conversion aborts with no done pulse.
    d0 = done_cnt;
    bin_in = 14'd8765;
    load = 1'b1;
    wait_busy(1'b1, "t6_accept");
    load = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_zero", {13'h0, busy, done, overflow, bcd_out}, 32'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 32'd0);
    chk("t6_bcd_zero", {16'h0, bcd_out}, 32'h0);
    run(14'd8765, 16'h8765, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
